adc_trig_capture_mc: RTL and testbench

Multi-channel triggered ADC capture unit. It is the parametrised successor of the single-unit triggered data-acquisition block, generalised in channel count, sample width and buffer depth. It adds a pre-trigger ring buffer, selectable edge trigger, force/abort controls and auto-rearm mode. It sits between the ADC sample stream and the AXI-lite register front end; its cfg and status ports are mapped to registers by that front end.

---
 rtl/adc_trig_capture_mc.sv | 155 +++++++++++++++
 tb/tb_adc_trig_capture_mc.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_trig_capture_mc.sv
// adc_trig_capture_mc: multi-channel triggered ADC capture with pre-trigger ring buffer,
// edge/force trigger, abort and auto-rearm; per-channel sample RAM with registered read.
module adc_trig_capture_mc #(
    parameter int N_CH       = 2,
    parameter int ADC_WIDTH  = 16,
    parameter int DEPTH_LOG2 = 10,
    parameter int CH_W       = 1
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      adc_valid,
    input  logic [N_CH*ADC_WIDTH-1:0] adc_data,
    input  logic [CH_W-1:0]           cfg_trig_ch,
    input  logic [ADC_WIDTH-1:0]      cfg_trig_level,
    input  logic                      cfg_trig_falling,
    input  logic                      cfg_auto,
    input  logic [DEPTH_LOG2-1:0]     cfg_pretrig,
    input  logic                      arm,
    input  logic                      force_trig,
    input  logic                      abort,
    input  logic                      ack,
    output logic [2:0]                state,
    output logic                      done,
    output logic [DEPTH_LOG2-1:0]     trig_addr,
    output logic [DEPTH_LOG2-1:0]     start_addr,
    output logic [31:0]               capture_cnt,
    input  logic                      rd_en,
    input  logic [CH_W-1:0]           rd_ch,
    input  logic [DEPTH_LOG2-1:0]     rd_addr,
    output logic                      rd_valid,
    output logic [ADC_WIDTH-1:0]      rd_data
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [2:0] {IDLE = 3'd0, PRE = 3'd1, WAIT_TRIG = 3'd2, POST = 3'd3, DONE = 3'd4} state_t;

    state_t st, nxt;
    logic [CH_W-1:0] trig_ch_l;
    logic signed [ADC_WIDTH-1:0] level_l, prev, cur;
    logic falling_l, auto_l, prev_valid, force_pend;
    logic [DEPTH_LOG2-1:0] pretrig_l, wptr, fill, raddr;
    logic [DEPTH_LOG2:0] post, post_end;
    logic [ADC_WIDTH-1:0] mem [N_CH][DEPTH];
    logic we, go, reinit, hit, finish, edge_hit;

    assign state = st;
    assign done = st == DONE;
    assign cur = adc_data[trig_ch_l*ADC_WIDTH +: ADC_WIDTH];
    assign we = adc_valid && (st == PRE || st == WAIT_TRIG || st == POST);
    assign post_end = (DEPTH_LOG2+1)'(DEPTH) - (DEPTH_LOG2+1)'(pretrig_l);
    assign raddr = start_addr + rd_addr;
    assign edge_hit = prev_valid && (falling_l ? (prev >= level_l && cur < level_l)
                                               : (prev < level_l && cur >= level_l));

    always_comb begin
        nxt = st;
        go = 1'b0;
        reinit = 1'b0;
        hit = 1'b0;
        finish = 1'b0;
        case (st)
            IDLE: if (arm) begin
                nxt = PRE;
                go = 1'b1;
                reinit = 1'b1;
            end
            PRE: if (pretrig_l == '0 || (adc_valid && fill + DEPTH_LOG2'(1) == pretrig_l)) nxt = WAIT_TRIG;
            WAIT_TRIG: if (adc_valid && (edge_hit || force_trig || force_pend)) begin
                hit = 1'b1;
                finish = post_end == (DEPTH_LOG2+1)'(1);
                nxt = finish ? DONE : POST;
            end
            POST: if (adc_valid && post + (DEPTH_LOG2+1)'(1) == post_end) begin
                finish = 1'b1;
                nxt = DONE;
            end
            DONE: if (arm || ack) begin
                go = arm;
                reinit = arm || auto_l;
                nxt = (arm || auto_l) ? PRE : IDLE;
            end
            default: nxt = IDLE;
        endcase
        // abort overrides every other pulse, including a trigger in the same cycle
        if (abort) begin
            nxt = IDLE;
            go = 1'b0;
            reinit = 1'b0;
            hit = 1'b0;
            finish = 1'b0;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            st <= IDLE;
            wptr <= '0;
            fill <= '0;
            post <= '0;
            prev <= '0;
            prev_valid <= 1'b0;
            force_pend <= 1'b0;
            trig_ch_l <= '0;
            level_l <= '0;
            falling_l <= 1'b0;
            auto_l <= 1'b0;
            pretrig_l <= '0;
            trig_addr <= '0;
            start_addr <= '0;
            capture_cnt <= '0;
        end else begin
            st <= nxt;
            force_pend <= st == WAIT_TRIG && !hit && (force_pend || force_trig);
            if (go) begin
                trig_ch_l <= cfg_trig_ch;
                level_l <= cfg_trig_level;
                falling_l <= cfg_trig_falling;
                auto_l <= cfg_auto;
                pretrig_l <= cfg_pretrig;
            end
            if (reinit) begin
                wptr <= '0;
                fill <= '0;
                prev_valid <= 1'b0;
            end else if (we) begin
                wptr <= wptr + DEPTH_LOG2'(1);
                fill <= fill + DEPTH_LOG2'(1);
                prev <= cur;
                prev_valid <= 1'b1;
            end
            if (hit) begin
                trig_addr <= wptr;
                start_addr <= wptr - pretrig_l;
                post <= (DEPTH_LOG2+1)'(1);
            end else if (st == POST && adc_valid) begin
                post <= post + (DEPTH_LOG2+1)'(1);
            end
            if (finish) capture_cnt <= capture_cnt + 32'd1;
        end
    end

    always_ff @(posedge ACLK)
        if (we)
            for (int c = 0; c < N_CH; c++) mem[c][wptr] <= adc_data[c*ADC_WIDTH +: ADC_WIDTH];

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rd_valid <= 1'b0;
            rd_data <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= mem[rd_ch][raddr];
        end
    end
endmodule

// File: tb/tb_adc_trig_capture_mc.sv
// tb_adc_trig_capture_mc: scenario tasks for the triggered capture unit; read data is
// checked through an expected-value queue drained by a read-port monitor.
module tb_adc_trig_capture_mc;
    localparam int NC = 2, W = 16, DL = 4, CW = 1;

    logic ACLK = 1'b0, ARESET = 1'b1;
    logic adc_valid = 1'b0;
    logic [NC*W-1:0] adc_data = '0;
    logic [CW-1:0] cfg_trig_ch = '0;
    logic [W-1:0] cfg_trig_level = '0;
    logic cfg_trig_falling = 1'b0, cfg_auto = 1'b0;
    logic [DL-1:0] cfg_pretrig = '0;
    logic arm = 1'b0, force_trig = 1'b0, abort = 1'b0, ack = 1'b0;
    logic [2:0] state;
    logic done;
    logic [DL-1:0] trig_addr, start_addr;
    logic [31:0] capture_cnt;
    logic rd_en = 1'b0;
    logic [CW-1:0] rd_ch = '0;
    logic [DL-1:0] rd_addr = '0;
    logic rd_valid;
    logic [W-1:0] rd_data;

    int checks = 0, errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_d;

    adc_trig_capture_mc #(.N_CH(NC), .ADC_WIDTH(W), .DEPTH_LOG2(DL), .CH_W(CW)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .adc_valid(adc_valid), .adc_data(adc_data),
        .cfg_trig_ch(cfg_trig_ch), .cfg_trig_level(cfg_trig_level),
        .cfg_trig_falling(cfg_trig_falling), .cfg_auto(cfg_auto), .cfg_pretrig(cfg_pretrig),
        .arm(arm), .force_trig(force_trig), .abort(abort), .ack(ack),
        .state(state), .done(done), .trig_addr(trig_addr), .start_addr(start_addr),
        .capture_cnt(capture_cnt), .rd_en(rd_en), .rd_ch(rd_ch), .rd_addr(rd_addr),
        .rd_valid(rd_valid), .rd_data(rd_data)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

    always @(negedge ACLK) begin
        if (rd_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: rd_valid with no pending read, rd_data=%0d", $signed(rd_data));
            end else begin
                exp_d = exp_q.pop_front();
                if (rd_data !== exp_d) begin
                    errors++;
                    $display("FAIL rd_data: got %0d, expected %0d", $signed(rd_data), $signed(exp_d));
                end
            end
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic pulse_arm();
        arm = 1'b1; tick(); arm = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1; tick(); ack = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1; tick(); abort = 1'b0;
    endtask

    task automatic setup(input int ch, input int level, input bit fall, input bit au, input int pre);
        cfg_trig_ch = CW'(ch);
        cfg_trig_level = W'(level);
        cfg_trig_falling = fall;
        cfg_auto = au;
        cfg_pretrig = DL'(pre);
    endtask

    task automatic read(input int ch, input int idx, input int val);
        exp_q.push_back(W'(val));
        rd_en = 1'b1; rd_ch = CW'(ch); rd_addr = DL'(idx);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic drain(input string name);
        tick(); tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d reads never answered, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    function automatic logic [NC*W-1:0] sample(input int mode, input int k);
        int a, b;
        a = mode == 0 ? 10*k : mode == 1 ? k : 1000 + k;
        b = mode == 0 ? -k : mode == 1 ? -20*k : 0;
        return {W'(b), W'(a)};
    endfunction

    // mode 0: ch0=10k ch1=-k; mode 1: ch0=k ch1=-20k; mode 2: ch0=1000+k with a force pulse before k=3
    task automatic ramp(input int mode, input bit toggle, input int max_valid, output int n);
        bit forced = 1'b0;
        n = 0;
        for (int cyc = 0; cyc < 300 && !done && n < max_valid; cyc++) begin
            if (mode == 2 && n == 3 && !forced) begin
                adc_valid = 1'b0; force_trig = 1'b1; adc_data = {NC{16'h7FFF}};
                tick();
                force_trig = 1'b0; forced = 1'b1;
            end else if (toggle && cyc % 2 == 1) begin
                adc_valid = 1'b0; adc_data = {NC{16'h7FFF}};
                tick();
            end else begin
                adc_valid = 1'b1; adc_data = sample(mode, n);
                n++;
                tick();
            end
        end
        adc_valid = 1'b0;
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        repeat (2) tick();
        checks++;
        if (state !== 3'd0 || done !== 1'b0 || trig_addr !== '0 || start_addr !== '0 ||
            capture_cnt !== 32'd0 || rd_valid !== 1'b0 || rd_data !== '0) begin
            errors++;
            $display("FAIL reset: state=%0d done=%0b trig=%0d start=%0d cnt=%0d rdv=%0b rdd=%0d, expected all 0",
                     state, done, trig_addr, start_addr, capture_cnt, rd_valid, rd_data);
        end
        ARESET = 1'b0;
        tick();
    endtask

    task automatic test_rising();
        int n;
        setup(0, 100, 1'b0, 1'b0, 4);
        pulse_arm();
        checks++;
        if (state !== 3'd1) begin errors++; $display("FAIL arm_state: got %0d, expected 1", state); end
        ramp(0, 1'b0, 100, n);
        checks++;
        if (n != 22) begin errors++; $display("FAIL rise_samples: done after %0d samples, expected 22", n); end
        checks++;
        if (state !== 3'd4 || done !== 1'b1) begin
            errors++; $display("FAIL rise_done: state=%0d done=%0b, expected 4/1", state, done);
        end
        checks++;
        if (trig_addr !== 4'd10 || start_addr !== 4'd6) begin
            errors++; $display("FAIL rise_addr: trig=%0d start=%0d, expected 10/6", trig_addr, start_addr);
        end
        checks++;
        if (capture_cnt !== 32'd1) begin errors++; $display("FAIL rise_cnt: got %0d, expected 1", capture_cnt); end
        read(0, 0, 60); read(0, 4, 100); read(0, 15, 210);
        read(1, 4, -10); read(1, 15, -21); read(0, 10, 160);
        drain("rise");
        pulse_ack();
        checks++;
        if (state !== 3'd0 || done !== 1'b0) begin
            errors++; $display("FAIL ack_idle: state=%0d done=%0b, expected 0/0", state, done);
        end
    endtask

    task automatic test_falling();
        int n;
        setup(1, -50, 1'b1, 1'b0, 2);
        pulse_arm();
        ramp(1, 1'b0, 100, n);
        checks++;
        if (n != 17) begin errors++; $display("FAIL fall_samples: done after %0d samples, expected 17", n); end
        checks++;
        if (trig_addr !== 4'd3 || start_addr !== 4'd1 || capture_cnt !== 32'd2) begin
            errors++;
            $display("FAIL fall_addr: trig=%0d start=%0d cnt=%0d, expected 3/1/2", trig_addr, start_addr, capture_cnt);
        end
        read(1, 2, -60); read(1, 1, -40); read(1, 0, -20); read(1, 15, -320); read(0, 2, 3);
        drain("fall");
        pulse_ack();
    endtask

    task automatic test_force();
        int n;
        setup(0, 32767, 1'b0, 1'b0, 0);
        pulse_arm();
        ramp(2, 1'b0, 100, n);
        checks++;
        if (n != 19) begin errors++; $display("FAIL force_samples: done after %0d samples, expected 19", n); end
        checks++;
        if (trig_addr !== 4'd3 || start_addr !== 4'd3 || capture_cnt !== 32'd3) begin
            errors++;
            $display("FAIL force_addr: trig=%0d start=%0d cnt=%0d, expected 3/3/3", trig_addr, start_addr, capture_cnt);
        end
        read(0, 0, 1003); read(0, 1, 1004); read(0, 15, 1018);
        drain("force");
        pulse_ack();
    endtask

    task automatic test_abort();
        int n;
        setup(0, 100, 1'b0, 1'b0, 4);
        pulse_arm();
        ramp(0, 1'b0, 15, n);
        checks++;
        if (state !== 3'd3) begin errors++; $display("FAIL abort_pre: state=%0d, expected 3", state); end
        pulse_abort();
        checks++;
        if (state !== 3'd0 || done !== 1'b0 || capture_cnt !== 32'd3) begin
            errors++;
            $display("FAIL abort: state=%0d done=%0b cnt=%0d, expected 0/0/3", state, done, capture_cnt);
        end
        pulse_arm();
        ramp(0, 1'b0, 100, n);
        checks++;
        if (n != 22 || trig_addr !== 4'd10 || capture_cnt !== 32'd4) begin
            errors++;
            $display("FAIL rearm: samples=%0d trig=%0d cnt=%0d, expected 22/10/4", n, trig_addr, capture_cnt);
        end
        read(0, 4, 100);
        drain("rearm");
        pulse_ack();
    endtask

    task automatic test_auto();
        int n;
        setup(0, 100, 1'b0, 1'b1, 4);
        pulse_arm();
        cfg_trig_level = W'(30000); cfg_trig_falling = 1'b1; cfg_auto = 1'b0; cfg_pretrig = DL'(9);
        for (int i = 0; i < 3; i++) begin
            ramp(0, 1'b0, 100, n);
            checks++;
            if (n != 22 || trig_addr !== 4'd10 || start_addr !== 4'd6 || capture_cnt !== 32'(5 + i)) begin
                errors++;
                $display("FAIL auto_%0d: samples=%0d trig=%0d start=%0d cnt=%0d, expected 22/10/6/%0d",
                         i, n, trig_addr, start_addr, capture_cnt, 5 + i);
            end
            if (i < 2) begin
                pulse_ack();
                checks++;
                if (state !== 3'd1) begin errors++; $display("FAIL auto_rearm_%0d: state=%0d, expected 1", i, state); end
            end
        end
        read(0, 15, 210);
        drain("auto");
        pulse_abort();
        checks++;
        if (state !== 3'd0 || capture_cnt !== 32'd7) begin
            errors++; $display("FAIL auto_abort: state=%0d cnt=%0d, expected 0/7", state, capture_cnt);
        end
    endtask

    task automatic test_toggle_and_async_reset();
        int n;
        setup(0, 100, 1'b0, 1'b0, 4);
        pulse_arm();
        ramp(0, 1'b1, 100, n);
        checks++;
        if (n != 22 || trig_addr !== 4'd10 || start_addr !== 4'd6 || capture_cnt !== 32'd8) begin
            errors++;
            $display("FAIL toggle: samples=%0d trig=%0d start=%0d cnt=%0d, expected 22/10/6/8",
                     n, trig_addr, start_addr, capture_cnt);
        end
        read(0, 0, 60); read(0, 4, 100); read(0, 15, 210); read(1, 4, -10);
        drain("toggle");
        pulse_ack();
        pulse_arm();
        ramp(0, 1'b0, 15, n);
        ARESET = 1'b1;
        #2;
        checks++;
        if (state !== 3'd0 || done !== 1'b0 || trig_addr !== '0 || start_addr !== '0 ||
            capture_cnt !== 32'd0 || rd_valid !== 1'b0 || rd_data !== '0) begin
            errors++;
            $display("FAIL async_reset: state=%0d done=%0b trig=%0d start=%0d cnt=%0d rdv=%0b rdd=%0d, expected all 0",
                     state, done, trig_addr, start_addr, capture_cnt, rd_valid, rd_data);
        end
        tick();
        ARESET = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_rising();
        test_falling();
        test_force();
        test_abort();
        test_auto();
        test_toggle_and_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
